// File: rtl/sum_uart_sequencer.sv
// sum_uart_sequencer: snapshots A, B and A+B, then sends "A+B=SS\r\n" as hex ASCII over a start/busy UART TX.
module sum_uart_sequencer #(
    parameter int OP_W         = 3,
    parameter int SUM_W        = 5,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
    input  logic             send_req,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             tx_busy,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    output logic             seq_busy,
    output logic             frame_done,
    output logic             overrun,
    output logic             err_timeout
);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t        state, state_nx;
    logic          prev_req, request;
    logic          pending, pending_nx, overrun_nx, err_nx;
    logic [2:0]    byte_idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    snap_a, snap_b;
    logic [7:0]    snap_sum, tx_hold, cur_byte;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    assign request    = send_req & ~prev_req & tx_en;
    assign tx_start   = state == START;
    assign seq_busy   = state inside {LOAD, START, WAIT_HI, WAIT_LO};
    assign frame_done = state == DONE;
    // tx_hold keeps the last sent byte on the bus until the next START
    assign tx_data    = tx_start ? cur_byte : tx_hold;

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            3'd0: cur_byte = hex(snap_a);
            3'd1: cur_byte = 8'h2B;
            3'd2: cur_byte = hex(snap_b);
            3'd3: cur_byte = 8'h3D;
            3'd4: cur_byte = hex(snap_sum[7:4]);
            3'd5: cur_byte = hex(snap_sum[3:0]);
            3'd6: cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        overrun_nx = overrun;
        err_nx     = err_timeout;
        idx_nx     = byte_idx;
        cnt_nx     = cnt;
        if (request && state != IDLE) begin
            if (pending)
                overrun_nx = 1'b1;
            else
                pending_nx = 1'b1;
        end
        case (state)
            IDLE: begin
                state_nx   = (request || pending) ? LOAD : IDLE;
                pending_nx = pending & request;
            end
            LOAD: begin
                idx_nx   = 3'd0;
                state_nx = START;
            end
            START: begin
                cnt_nx   = '0;
                state_nx = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nx = WAIT_LO;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    err_nx     = 1'b1;
                    pending_nx = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_nx = (byte_idx == 3'd7) ? DONE : START;
                    idx_nx   = (byte_idx == 3'd7) ? byte_idx : byte_idx + 3'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prev_req    <= 1'b0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            err_timeout <= 1'b0;
            byte_idx    <= 3'd0;
            cnt         <= '0;
            snap_a      <= 4'd0;
            snap_b      <= 4'd0;
            snap_sum    <= 8'd0;
            tx_hold     <= 8'd0;
        end else begin
            state       <= state_nx;
            prev_req    <= send_req;
            pending     <= pending_nx;
            overrun     <= overrun_nx;
            err_timeout <= err_nx;
            byte_idx    <= idx_nx;
            cnt         <= cnt_nx;
            if (state == LOAD) begin
                snap_a   <= 4'(op_a);
                snap_b   <= 4'(op_b);
                snap_sum <= 8'(sum_in);
            end
            if (tx_start)
                tx_hold <= cur_byte;
        end
    end
endmodule

// File: tb/tb_sum_uart_sequencer.sv
// tb_sum_uart_sequencer: directed bench with a byte scoreboard and a simple UART TX busy model.
module tb_sum_uart_sequencer;
    logic       clk = 1'b0, reset = 1'b1, tx_en = 1'b1, send_req = 1'b0, tx_busy = 1'b0;
    logic [2:0] op_a = 3'd0, op_b = 3'd0;
    logic [4:0] sum_in = 5'd0;
    logic [7:0] tx_data, exp_b;
    logic       tx_start, seq_busy, frame_done, overrun, err_timeout;
    int         errors = 0, checks = 0, done_cnt = 0, bcnt = 0, base = 0;
    bit         uart_on = 1'b1, prev_start = 1'b0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sum_uart_sequencer dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .send_req(send_req),
        .op_a(op_a), .op_b(op_b), .sum_in(sum_in), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_start(tx_start), .seq_busy(seq_busy),
        .frame_done(frame_done), .overrun(overrun), .err_timeout(err_timeout)
    );

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + (8'(n) - 8'd10);
    endfunction

    task automatic push_frame(input logic [3:0] a, input logic [3:0] b, input logic [7:0] s);
        q.push_back(hx(a));
        q.push_back(8'h2B);
        q.push_back(hx(b));
        q.push_back(8'h3D);
        q.push_back(hx(s[7:4]));
        q.push_back(hx(s[3:0]));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_start) return;
        end
        chk("wait_start", 8'(tx_start), 8'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        chk("wait_done", 8'(frame_done), 8'd1);
    endtask

    // UART model: busy rises right after a sampled start and stays high for 10 cycles
    always @(negedge clk) begin
        if (reset) bcnt = 0;
        else if (tx_start && uart_on) bcnt = 10;
        else if (bcnt > 0) bcnt--;
        tx_busy = bcnt > 0;
    end

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (tx_start) begin
            chk("double_start", 8'(prev_start), 8'd0);
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL extra_start: observed=%h expected=none", tx_data);
            end
            if (q.size() > 0) begin
                exp_b = q.pop_front();
                chk("frame_byte", tx_data, exp_b);
            end
        end
        prev_start = tx_start;
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            send_req = ~send_req;
            chk("rst_start", 8'(tx_start), 8'd0);
            chk("rst_busy", 8'(seq_busy), 8'd0);
            chk("rst_data", tx_data, 8'h00);
        end
        chk("rst_done", 8'(frame_done), 8'd0);
        chk("rst_ovr", 8'(overrun), 8'd0);
        chk("rst_err", 8'(err_timeout), 8'd0);
        send_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // basic frame with first-start latency and mid-frame operand change
        op_a = 3; op_b = 5; sum_in = 8;
        push_frame(3, 5, 8);
        base = done_cnt;
        send_req = 1'b1;
        @(negedge clk);
        chk("lat_load_start", 8'(tx_start), 8'd0);
        chk("lat_load_busy", 8'(seq_busy), 8'd1);
        @(negedge clk);
        chk("lat_first_start", 8'(tx_start), 8'd1);
        op_a = 0; op_b = 0; sum_in = 0; send_req = 1'b0;
        wait_done(200);
        repeat (20) @(negedge clk);
        chk("basic_done_cnt", 8'(done_cnt - base), 8'd1);
        chk("basic_q_empty", 8'(q.size()), 8'd0);
        chk("basic_idle", 8'(seq_busy), 8'd0);
        chk("basic_hold", tx_data, 8'h0A);
        // hex letters in the sum digits
        op_a = 7; op_b = 7; sum_in = 14;
        push_frame(7, 7, 14);
        send_req = 1'b1;
        wait_done(200);
        send_req = 1'b0;
        @(negedge clk);
        op_a = 0; op_b = 1; sum_in = 31;
        push_frame(0, 1, 31);
        send_req = 1'b1;
        wait_done(200);
        send_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("hex_q_empty", 8'(q.size()), 8'd0);
        // one pending follow-up frame, third request overruns
        base = done_cnt;
        op_a = 1; op_b = 2; sum_in = 3;
        push_frame(1, 2, 3);
        send_req = 1'b1;
        repeat (3) wait_start(100);
        send_req = 1'b0;
        op_a = 4; op_b = 5; sum_in = 9;
        push_frame(4, 5, 9);
        @(negedge clk);
        send_req = 1'b1;
        @(negedge clk);
        chk("no_overrun_yet", 8'(overrun), 8'd0);
        send_req = 1'b0;
        @(negedge clk);
        send_req = 1'b1;
        @(negedge clk);
        chk("overrun_set", 8'(overrun), 8'd1);
        send_req = 1'b0;
        wait_done(200);
        @(negedge clk);
        chk("gap_idle", 8'(seq_busy), 8'd0);
        @(negedge clk);
        chk("gap_load_busy", 8'(seq_busy), 8'd1);
        chk("gap_load_start", 8'(tx_start), 8'd0);
        @(negedge clk);
        chk("gap_start", 8'(tx_start), 8'd1);
        wait_done(200);
        repeat (30) @(negedge clk);
        chk("queue_done_cnt", 8'(done_cnt - base), 8'd2);
        chk("queue_q_empty", 8'(q.size()), 8'd0);
        // UART never goes busy
        base = done_cnt;
        uart_on = 1'b0;
        op_a = 2; op_b = 2; sum_in = 4;
        q.push_back(hx(4'd2));
        send_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("tmo_start", 8'(tx_start), 8'd1);
        send_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("tmo_err_early", 8'(err_timeout), 8'd0);
        chk("tmo_busy_early", 8'(seq_busy), 8'd1);
        @(negedge clk);
        chk("tmo_err", 8'(err_timeout), 8'd1);
        chk("tmo_busy_drop", 8'(seq_busy), 8'd0);
        repeat (30) @(negedge clk);
        chk("tmo_no_done", 8'(done_cnt - base), 8'd0);
        chk("tmo_q_empty", 8'(q.size()), 8'd0);
        uart_on = 1'b1;
        // request with tx_en low is ignored
        tx_en = 1'b0;
        send_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("gate_busy", 8'(seq_busy), 8'd0);
        chk("gate_no_done", 8'(done_cnt - base), 8'd0);
        chk("sticky_overrun", 8'(overrun), 8'd1);
        chk("sticky_err", 8'(err_timeout), 8'd1);
        send_req = 1'b0;
        tx_en = 1'b1;
        @(negedge clk);
        // reset during byte 4 aborts the frame and clears flags
        op_a = 6; op_b = 1; sum_in = 7;
        push_frame(6, 1, 7);
        send_req = 1'b1;
        repeat (5) wait_start(100);
        send_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        chk("abort_start", 8'(tx_start), 8'd0);
        chk("abort_busy", 8'(seq_busy), 8'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_idle_busy", 8'(seq_busy), 8'd0);
        chk("abort_ovr_clr", 8'(overrun), 8'd0);
        chk("abort_err_clr", 8'(err_timeout), 8'd0);
        chk("abort_data", tx_data, 8'h00);
        base = done_cnt;
        op_a = 5; op_b = 3; sum_in = 8;
        push_frame(5, 3, 8);
        send_req = 1'b1;
        wait_done(200);
        send_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("after_abort_done", 8'(done_cnt - base), 8'd1);
        chk("after_abort_q", 8'(q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sum_uart_sequencer.md
Name: sum_uart_sequencer

Overview:
Sequences the byte-wide UART transmitter for the sum/latch system. On a send request it snapshots operand A, operand B and their sum, then emits one ASCII frame "A+B=SS\r\n" in upper-case hex, one byte at a time. Each byte uses a start/busy handshake with the UART TX. Sits between the operand latches/adder and the UART TX core and is the only master of the TX byte interface.

Parameters:
OP_W, 3, operand width in bits (1..4); each operand is sent as one hex digit, zero-extended.
SUM_W, 5, sum width in bits (5..8); the sum is always sent as two hex digits, zero-extended to 8 bits.
BUSY_TIMEOUT, 4, max cycles to wait for tx_busy to rise after tx_start (>=1).

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
tx_en  input  1  global enable; requests are ignored while low
send_req  input  1  send request; level sampled each cycle, rising edge detected internally
op_a  input  OP_W  latched operand A
op_b  input  OP_W  latched operand B
sum_in  input  SUM_W  adder result
tx_busy  input  1  UART TX busy (high while a byte is shifting)
tx_data  output  8  byte to transmit
tx_start  output  1  one-cycle start strobe to UART TX
seq_busy  output  1  high from frame acceptance until the last byte completes
frame_done  output  1  one-cycle pulse after the last byte (LF) completes
overrun  output  1  sticky: a request arrived while one frame was active and one was already pending
err_timeout  output  1  sticky: tx_busy failed to rise within BUSY_TIMEOUT cycles

Behaviour:
- Reset (sync, high) has priority over everything. Outputs: tx_data=0x00, tx_start=0, seq_busy=0, frame_done=0, overrun=0, err_timeout=0. FSM goes to IDLE, pending flag=0, edge-detector history=0. Reset mid-frame aborts the frame. No further tx_start is issued.
- Request = send_req rising edge (registered previous value) AND tx_en=1.
- States: IDLE, LOAD, START, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - request or pending=1 -> LOAD.
  - Pending is cleared when consumed.
- LOAD (1 cycle):
  - Snapshot op_a, op_b, sum_in into internal registers.
  - byte_idx=0; seq_busy=1.
  - -> START.
- START (1 cycle):
  - tx_data = frame byte[byte_idx]; tx_start=1.
  - Timeout counter cleared.
  - -> WAIT_HI.
- WAIT_HI:
  - tx_busy=1 -> WAIT_LO.
  - Otherwise count. After BUSY_TIMEOUT cycles without tx_busy: set err_timeout, drop seq_busy, discard pending, -> IDLE (frame aborted).
- WAIT_LO:
  - tx_busy=0 and byte_idx=7 -> DONE.
  - tx_busy=0 and byte_idx<7 -> byte_idx+1, -> START.
- DONE (1 cycle): frame_done=1, seq_busy=0, -> IDLE.
- tx_data is held stable from START until the next START. tx_start is never high for two consecutive cycles.
- Frame bytes, index 0..7:
  - 0: hex(A)
  - 1: 0x2B '+'
  - 2: hex(B)
  - 3: 0x3D '='
  - 4: hex(sum[7:4])
  - 5: hex(sum[3:0])
  - 6: 0x0D
  - 7: 0x0A
- hex(n): n 0..9 -> 0x30+n; n 10..15 -> 0x37+n (i.e. 'A'..'F').
- Request while seq_busy:
  - pending=0 -> set pending. Exactly one follow-up frame is sent after DONE, using operands snapshotted at its own LOAD.
  - pending=1 -> set overrun; the request is dropped.
- Request in the same cycle as DONE sets pending; the next frame starts via IDLE.
- Operand/sum input changes during a frame do not affect the frame in flight.
- tx_en going low mid-frame does not abort; it only blocks new requests.
- Sticky flags clear only on reset.
- Latency: request edge at cycle N -> LOAD at N+1 -> first tx_start at N+2.

Test Plan:
- Reset: drive reset=1 for 2 cycles with send_req toggling -> all outputs 0 and no tx_start.
- Basic frame: tx_en=1, A=3, B=5, sum=8, send_req 0->1, UART model raises busy 1 cycle after start for 10 cycles -> bytes 0x33 0x2B 0x35 0x3D 0x30 0x38 0x0D 0x0A in order; first tx_start 2 cycles after the edge; single frame_done.
- Hex letters: A=7, B=7, sum=14 -> bytes 4,5 = 0x30 0x45; with SUM_W=5, sum=31 -> 0x31 0x46.
- Queuing: second edge during byte 2 -> second frame follows with no gap beyond IDLE/LOAD. Third edge during the same frame -> overrun=1 and only 2 frames sent.
- Timeout: UART model never asserts busy -> err_timeout=1 exactly BUSY_TIMEOUT cycles after the first tx_start; seq_busy=0; no frame_done; no further tx_start.
- Gating/abort: send_req edge with tx_en=0 -> no activity. Reset asserted at byte 4 -> tx_start stays 0 and state is IDLE; a new request afterwards sends a full 8-byte frame.
